// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: memory-stage FSM states and load/store width codes.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // funct3 width codes for loads
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // funct3 width codes for stores
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Byte-enable pattern for a store before lane shifting; 0 for unknown widths.
  function automatic logic [3:0] store_base_mask(input logic [2:0] funct3);
    logic [3:0] m;
    case (funct3)
      SB:      m = 4'b0001;
      SH:      m = 4'b0011;
      SW:      m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane alignment for the memory stage: store mask/data,
// load extract/extend, and misalignment detection.
module load_store_align
  import rv32i_types::*;
(
  input  logic        data_read,
  input  logic        data_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        misaligned,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] load_ext
);

  logic [31:0] rdata_shifted;

  // Flag halfword/word accesses that straddle their natural boundary.
  always_comb begin
    misaligned = 1'b0;
    if (data_read || data_write) begin
      if ((funct3 == LH || funct3 == LHU) && byte_off[0]) begin
        misaligned = 1'b1;
      end else if (funct3 == LW && byte_off != 2'b00) begin
        misaligned = 1'b1;
      end
    end
  end

  // Shift store mask and data into the addressed byte lanes.
  always_comb begin
    wmask = 4'b0000;
    if (data_write) begin
      wmask = store_base_mask(funct3) << byte_off;
    end
    wdata = store_data << {byte_off, 3'b000};
  end

  // Bring the addressed lane down to bit 0, then extend by width.
  always_comb begin
    rdata_shifted = rdata >> {byte_off, 3'b000};
    case (funct3)
      LB:      load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      LBU:     load_ext = {24'h000000, rdata_shifted[7:0]};
      LH:      load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      LHU:     load_ext = {16'h0000, rdata_shifted[15:0]};
      LW:      load_ext = rdata_shifted;
      default: load_ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues one data-cache request per load/store held in
// MEM, stalls the pipeline until the response, and registers the load result.
module mem_stage_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   data_read_mem,
  input  logic                   data_write_mem,
  input  logic [2:0]             funct3_mem,
  input  logic [31:0]            alu_out_mem,
  input  logic [31:0]            data_wdata_mem,
  input  logic                   hold_ext,
  output logic [31:0]            dmem_addr,
  output logic                   dmem_read,
  output logic                   dmem_write,
  output logic [3:0]             dmem_wmask,
  output logic [31:0]            dmem_wdata,
  input  logic [31:0]            dmem_rdata,
  input  logic                   dmem_resp,
  output logic [31:0]            load_data_mem,
  output logic                   mem_stall,
  output logic                   misaligned,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  mem_state_t  state_q;
  logic        acc;
  logic [3:0]  wmask_c;
  logic [31:0] wdata_c;
  logic [31:0] load_ext;

  load_store_align u_align (
    .data_read  (data_read_mem),
    .data_write (data_write_mem),
    .funct3     (funct3_mem),
    .byte_off   (alu_out_mem[1:0]),
    .store_data (data_wdata_mem),
    .rdata      (dmem_rdata),
    .misaligned (misaligned),
    .wmask      (wmask_c),
    .wdata      (wdata_c),
    .load_ext   (load_ext)
  );

  // A real access is one the cache may see; misaligned ones never issue.
  always_comb begin
    acc = (data_read_mem | data_write_mem) & ~misaligned;
  end

  // Stall from the first IDLE cycle of an access through the response cycle.
  always_comb begin
    mem_stall = ((state_q == IDLE) && acc) || (state_q == REQ);
  end

  // Request FSM; request outputs are registered and frozen for all of REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      dmem_read     <= 1'b0;
      dmem_write    <= 1'b0;
      dmem_addr     <= 32'h0000_0000;
      dmem_wmask    <= 4'b0000;
      dmem_wdata    <= 32'h0000_0000;
      load_data_mem <= 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc) begin
            state_q    <= REQ;
            dmem_read  <= data_read_mem;
            dmem_write <= data_write_mem;
            dmem_addr  <= {alu_out_mem[31:2], 2'b00};
            dmem_wmask <= data_write_mem ? wmask_c : 4'b0000;
            dmem_wdata <= data_write_mem ? wdata_c : 32'h0000_0000;
          end
        end
        REQ: begin
          if (dmem_resp) begin
            state_q       <= DONE;
            dmem_read     <= 1'b0;
            dmem_write    <= 1'b0;
            dmem_addr     <= 32'h0000_0000;
            dmem_wmask    <= 4'b0000;
            dmem_wdata    <= 32'h0000_0000;
            // Stores leave a zero result so MEM/WB never sees stale load data.
            load_data_mem <= dmem_read ? load_ext : 32'h0000_0000;
          end
        end
        DONE: begin
          // Wait out any external freeze so the same instruction is not reissued.
          if (!hold_ext) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Saturating count of cycles this block held the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (mem_stall && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        data_read_mem;
  logic        data_write_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] alu_out_mem;
  logic [31:0] data_wdata_mem;
  logic        hold_ext;
  logic [31:0] dmem_addr;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] load_data_mem;
  logic        mem_stall;
  logic        misaligned;
  logic [31:0] stall_cycles;

  int total;
  int bad;

  mem_stage_ctrl #(
    .STALL_CNT_W (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_read_mem  (data_read_mem),
    .data_write_mem (data_write_mem),
    .funct3_mem     (funct3_mem),
    .alu_out_mem    (alu_out_mem),
    .data_wdata_mem (data_wdata_mem),
    .hold_ext       (hold_ext),
    .dmem_addr      (dmem_addr),
    .dmem_read      (dmem_read),
    .dmem_write     (dmem_write),
    .dmem_wmask     (dmem_wmask),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_resp      (dmem_resp),
    .load_data_mem  (load_data_mem),
    .mem_stall      (mem_stall),
    .misaligned     (misaligned),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Move just past the next rising edge, where inputs are driven.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample point, half a cycle away from the active edge.
  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] sc0;
    int stall_n;
    int read_n;
    int rise_n;
    int addr_bad;
    logic prev_read;

    total = 0;
    bad = 0;
    rst = 1'b1;
    data_read_mem = 1'b0;
    data_write_mem = 1'b0;
    funct3_mem = 3'b000;
    alu_out_mem = 32'h0;
    data_wdata_mem = 32'h0;
    hold_ext = 1'b0;
    dmem_rdata = 32'h0;
    dmem_resp = 1'b0;

    next_cyc();
    next_cyc();
    sample();
    chk("rst_read", {31'b0, dmem_read}, 32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_load", load_data_mem, 32'h0);
    chk("rst_cnt", stall_cycles, 32'd0);

    // lb at 0x1003, resp one cycle after entering REQ
    next_cyc();
    rst = 1'b0;
    data_read_mem = 1'b1;
    funct3_mem = 3'b000;
    alu_out_mem = 32'h0000_1003;
    sample();
    chk("lb_idle_stall", {31'b0, mem_stall}, 32'd1);
    chk("lb_idle_noreq", {31'b0, dmem_read}, 32'd0);
    next_cyc();
    sample();
    chk("lb_req_read", {31'b0, dmem_read}, 32'd1);
    chk("lb_req_addr", dmem_addr, 32'h0000_1000);
    chk("lb_req_mask", {28'b0, dmem_wmask}, 32'h0);
    next_cyc();
    dmem_resp = 1'b1;
    dmem_rdata = 32'h80AA_BBCC;
    sample();
    chk("lb_resp_stall", {31'b0, mem_stall}, 32'd1);
    chk("lb_resp_read", {31'b0, dmem_read}, 32'd1);
    next_cyc();
    dmem_resp = 1'b0;
    sample();
    chk("lb_done_data", load_data_mem, 32'hFFFF_FF80);
    chk("lb_done_stall", {31'b0, mem_stall}, 32'd0);
    chk("lb_done_read", {31'b0, dmem_read}, 32'd0);
    chk("lb_cnt", stall_cycles, 32'd3);
    next_cyc();
    data_read_mem = 1'b0;
    sample();
    chk("lb_idle_hold_data", load_data_mem, 32'hFFFF_FF80);

    // sh at 0x2002, resp after two REQ cycles
    next_cyc();
    data_write_mem = 1'b1;
    funct3_mem = 3'b001;
    alu_out_mem = 32'h0000_2002;
    data_wdata_mem = 32'h0000_1234;
    sample();
    chk("sh_idle_stall", {31'b0, mem_stall}, 32'd1);
    next_cyc();
    sample();
    chk("sh_mask", {28'b0, dmem_wmask}, 32'h0000_000C);
    chk("sh_wdata", dmem_wdata, 32'h1234_0000);
    chk("sh_write1", {31'b0, dmem_write}, 32'd1);
    chk("sh_noread", {31'b0, dmem_read}, 32'd0);
    next_cyc();
    sample();
    chk("sh_write2", {31'b0, dmem_write}, 32'd1);
    chk("sh_wdata2", dmem_wdata, 32'h1234_0000);
    next_cyc();
    dmem_resp = 1'b1;
    sample();
    chk("sh_resp_stall", {31'b0, mem_stall}, 32'd1);
    next_cyc();
    dmem_resp = 1'b0;
    sample();
    chk("sh_done_stall", {31'b0, mem_stall}, 32'd0);
    chk("sh_done_write", {31'b0, dmem_write}, 32'd0);
    chk("sh_done_mask", {28'b0, dmem_wmask}, 32'h0);
    chk("sh_done_load0", load_data_mem, 32'h0);
    chk("sh_cnt", stall_cycles, 32'd7);
    next_cyc();
    data_write_mem = 1'b0;

    // lw at 0x10, resp on the fifth REQ cycle
    sc0 = stall_cycles;
    stall_n = 0;
    read_n = 0;
    rise_n = 0;
    addr_bad = 0;
    prev_read = 1'b0;
    data_read_mem = 1'b1;
    funct3_mem = 3'b010;
    alu_out_mem = 32'h0000_0010;
    dmem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (mem_stall) stall_n++;
      if (dmem_read) begin
        read_n++;
        if (dmem_addr !== 32'h0000_0010) addr_bad++;
        if (!prev_read) rise_n++;
      end
      prev_read = dmem_read;
      if (i == 6) chk("lw_done_data", load_data_mem, 32'hDEAD_BEEF);
      next_cyc();
      dmem_resp = (i + 1 == 5);
      data_read_mem = (i + 1 <= 6);
    end
    chk("lw_stall_n", stall_n, 32'd6);
    chk("lw_read_n", read_n, 32'd5);
    chk("lw_one_req", rise_n, 32'd1);
    chk("lw_addr_stable", addr_bad, 32'd0);
    chk("lw_cnt_delta", stall_cycles - sc0, 32'd6);

    // lbu at 0x1001, then DONE frozen by hold_ext for three edges
    data_read_mem = 1'b1;
    funct3_mem = 3'b100;
    alu_out_mem = 32'h0000_1001;
    sample();
    next_cyc();
    dmem_resp = 1'b1;
    dmem_rdata = 32'h0000_A500;
    sample();
    next_cyc();
    dmem_resp = 1'b0;
    hold_ext = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("hold_noreq", {31'b0, dmem_read}, 32'd0);
      chk("hold_nostall", {31'b0, mem_stall}, 32'd0);
      chk("hold_data", load_data_mem, 32'h0000_00A5);
      next_cyc();
    end
    hold_ext = 1'b0;
    sample();
    chk("hold_last_noreq", {31'b0, dmem_read}, 32'd0);
    next_cyc();
    data_read_mem = 1'b0;
    sample();
    chk("hold_after_data", load_data_mem, 32'h0000_00A5);

    // misaligned lw at 0x3001
    next_cyc();
    data_read_mem = 1'b1;
    funct3_mem = 3'b010;
    alu_out_mem = 32'h0000_3001;
    sample();
    chk("mis_flag", {31'b0, misaligned}, 32'd1);
    chk("mis_stall", {31'b0, mem_stall}, 32'd0);
    next_cyc();
    sample();
    chk("mis_flag_held", {31'b0, misaligned}, 32'd1);
    chk("mis_noreq", {31'b0, dmem_read}, 32'd0);
    next_cyc();
    data_read_mem = 1'b0;
    sample();
    chk("mis_clear", {31'b0, misaligned}, 32'd0);

    // reset during REQ
    next_cyc();
    data_write_mem = 1'b1;
    funct3_mem = 3'b010;
    alu_out_mem = 32'h0000_5000;
    data_wdata_mem = 32'hCAFE_F00D;
    sample();
    next_cyc();
    rst = 1'b1;
    sample();
    chk("pre_rst_write", {31'b0, dmem_write}, 32'd1);
    next_cyc();
    rst = 1'b0;
    data_write_mem = 1'b0;
    sample();
    chk("rst_req_write", {31'b0, dmem_write}, 32'd0);
    chk("rst_req_mask", {28'b0, dmem_wmask}, 32'h0);
    chk("rst_req_wdata", dmem_wdata, 32'h0);
    chk("rst_req_addr", dmem_addr, 32'h0);
    chk("rst_req_load", load_data_mem, 32'h0);
    chk("rst_req_cnt", stall_cycles, 32'd0);

    // lhu at 0x4002 after reset
    next_cyc();
    data_read_mem = 1'b1;
    funct3_mem = 3'b101;
    alu_out_mem = 32'h0000_4002;
    sample();
    chk("lhu_idle_stall", {31'b0, mem_stall}, 32'd1);
    next_cyc();
    dmem_resp = 1'b1;
    dmem_rdata = 32'hF00D_0000;
    sample();
    chk("lhu_req_addr", dmem_addr, 32'h0000_4000);
    next_cyc();
    dmem_resp = 1'b0;
    sample();
    chk("lhu_data", load_data_mem, 32'h0000_F00D);
    chk("lhu_cnt", stall_cycles, 32'd2);
    next_cyc();
    data_read_mem = 1'b0;

    // stray resp while idle is ignored
    dmem_resp = 1'b1;
    dmem_rdata = 32'h1111_1111;
    sample();
    next_cyc();
    dmem_resp = 1'b0;
    sample();
    chk("stray_resp_data", load_data_mem, 32'h0000_F00D);
    chk("stray_resp_stall", {31'b0, mem_stall}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-access stage controller between the EX/MEM pipeline register and the MEM/WB register of the 5-stage RV32I pipeline.
- Turns the held load/store in MEM into a single-request handshake on the data-cache port.
- Generates byte masks and lane-shifted store data, and extracts and extends load data.
- Drives a pipeline-wide stall until the access completes.

Parameters:
STALL_CNT_W, 32, width of the saturating perf counter of cycles spent stalled on data memory

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
data_read_mem  in  1  instruction in MEM is a load
data_write_mem  in  1  instruction in MEM is a store
funct3_mem  in  3  load/store width: 000 b, 001 h, 010 w, 100 bu, 101 hu
alu_out_mem  in  32  effective byte address
data_wdata_mem  in  32  unshifted store data (rs2)
hold_ext  in  1  downstream or hazard hold, excluding this block's own stall
dmem_addr  out  32  word-aligned address {alu_out_mem[31:2],2'b00}
dmem_read  out  1  read request
dmem_write  out  1  write request
dmem_wmask  out  4  byte-enable mask
dmem_wdata  out  32  lane-aligned store data
dmem_rdata  in  32  read data, valid with dmem_resp
dmem_resp  in  1  one-cycle completion pulse
load_data_mem  out  32  extended load result for MEM/WB
mem_stall  out  1  pipeline stall request
misaligned  out  1  current access is misaligned; no request issued
stall_cycles  out  STALL_CNT_W  count of cycles with mem_stall=1, saturating

Behaviour:
- Access present: acc = (data_read_mem | data_write_mem) & ~misaligned.
- misaligned (combinational) is set when either holds:
  - h/hu with addr[0]=1
  - w with addr[1:0]≠0
- FSM states: IDLE, REQ, DONE.
  - IDLE, acc=1: mem_stall=1 combinationally; next state REQ.
  - IDLE, acc=0: mem_stall=0; stay IDLE.
  - REQ: dmem_read/dmem_write registered, asserted for every REQ cycle; addr, mask and data held stable; mem_stall=1.
  - REQ, dmem_resp=1: capture extended load data into load register; next state DONE. mem_stall is still 1 in the resp cycle.
  - DONE: mem_stall=0, no request. Stay DONE while hold_ext=1; otherwise go to IDLE. This stops the same instruction being re-issued while the pipeline is frozen.
- Minimum latency: 3 cycles (IDLE→REQ→DONE) with a same-cycle resp; each extra wait cycle adds one.
- Exactly one request per instruction. A resp seen in IDLE or DONE is ignored.
- Store mask and data, with o = addr[1:0]:
  - wmask = base << o, where base is 0001 (b), 0011 (h), 1111 (w).
  - wdata = data_wdata_mem << (8*o).
  - dmem_wmask = 0 for loads and when idle.
- Load extraction from dmem_rdata >> (8*o):
  - b: sign-extend bit 7.
  - bu: zero-extend byte.
  - h: sign-extend bit 15.
  - hu: zero-extend half.
  - w: unchanged.
  - Undefined funct3 returns 0.
- load_data_mem is driven from the load register (valid in DONE and held until the next capture); it is 0 for stores.
- Misaligned access: no request; mem_stall=0; misaligned=1 for as long as the instruction is held.
- Neither read nor write asserted: block is transparent, stays IDLE, all request outputs are 0.
- stall_cycles increments on each mem_stall=1 cycle and saturates at all-ones.
- Reset (including mid-REQ): state→IDLE; dmem_read/write, wmask and wdata→0; load register→0; stall_cycles→0.
  - An outstanding cache access is not cancelled. The cache is reset by the same rst.

Decomposition:
- Shared package rv32i_types gains:
  - mem_state_t enum {IDLE, REQ, DONE}.
  - Width constants: lb=3'b000, lh, lw, lbu, lhu for loads; sb, sh, sw for stores.
- One combinational sub-module, load_store_align: mask, store shift, load extract and misaligned. The FSM and counter stay in mem_stage_ctrl.

Test Plan:
- lb at 0x1003, rdata 0x80AA_BBCC, resp 1 cycle after REQ → load_data_mem=0xFFFF_FF80 in DONE; one dmem_read cycle pair; dmem_addr=0x1000.
- sh at 0x2002, rs2=0x0000_1234 → dmem_wmask=1100, dmem_wdata=0x1234_0000, dmem_write held until resp; mem_stall drops in DONE.
- lw with resp delayed 4 cycles → mem_stall high for 6 cycles total; stall_cycles increments by 6; single request, stable address.
- DONE with hold_ext=1 for 3 cycles → no second request; load_data_mem stable; IDLE after hold_ext falls.
- lw at 0x3001 → misaligned=1, dmem_read=0, mem_stall=0.
- rst during REQ → next cycle all dmem outputs 0, state IDLE; a subsequent lhu at 0x4002 with rdata 0xF00D_0000 returns 0x0000_F00D.
